// File: rtl/ssp_tx_ctrl_pkg.sv
// Shared definitions for the synchronous serial port transmit controller.
package ssp_tx_ctrl_pkg;
    localparam int DATA_W      = 8;
    localparam int DIV_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } ssp_state_t;
endpackage

// File: rtl/ssp_clk_div.sv
// SSPCLKOUT half-period divider: strobes mark the PCLK edge that ends each half.
module ssp_clk_div
    import ssp_tx_ctrl_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic PCLK,
    input  logic CLEAR,
    input  logic en,
    output logic rise,
    output logic fall
);
    logic [7:0] cnt;
    logic       phase;
    logic       wrap;

    // phase 0 is the high half of a period, so a fresh enable starts high
    assign wrap = en && (cnt == 8'(DIV - 1));
    assign fall = wrap && !phase;
    assign rise = wrap && phase;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/ssp_tx_ctrl.sv
// Transmit side of a synchronous serial port: pops FIFO words into a hold
// register and serialises them MSB first behind a one-period frame sync.
//
//   state | meaning
//   IDLE  | line quiet, SSPOE_B high, waiting for a held word
//   SYNC  | one SSPCLKOUT period with SSPFSSOUT high
//   SHIFT | eight data periods, SSPTXD changes with each SSPCLKOUT rise
module ssp_tx_ctrl
    import ssp_tx_ctrl_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] TxData,
    output logic              shf_read_ready,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              tx_busy
);
    ssp_state_t        state, state_nxt;
    logic [DATA_W-1:0] hold, shift;
    logic              hold_valid, cap_pending;
    logic [2:0]        bit_cnt;
    logic              div_en, div_rise, div_fall;
    logic              pop_go, enter_sync, sync_end, shift_rise;

    ssp_clk_div #(.DIV(DIV)) u_div (
        .PCLK  (PCLK),
        .CLEAR (CLEAR),
        .en    (div_en),
        .rise  (div_rise),
        .fall  (div_fall)
    );

    assign div_en     = (state != IDLE);
    assign pop_go     = !fifo_empty && !hold_valid && !shf_read_ready && !cap_pending;
    assign sync_end   = (state == SYNC) && div_rise;
    assign shift_rise = (state == SHIFT) && div_rise;
    assign enter_sync = (state_nxt == SYNC) && (state != SYNC);
    assign SSPTXD     = shift[DATA_W-1];
    assign tx_busy    = shf_read_ready || cap_pending || hold_valid || (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hold_valid) state_nxt = SYNC;
            SYNC:    if (div_rise) state_nxt = SHIFT;
            SHIFT:   if (div_rise && bit_cnt == 3'd0) state_nxt = hold_valid ? SYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state          <= IDLE;
            shf_read_ready <= 1'b0;
            cap_pending    <= 1'b0;
            hold           <= '0;
            hold_valid     <= 1'b0;
            shift          <= '0;
            bit_cnt        <= '0;
            SSPCLKOUT      <= 1'b0;
            SSPFSSOUT      <= 1'b0;
            SSPOE_B        <= 1'b1;
        end else begin
            state          <= state_nxt;
            shf_read_ready <= pop_go;
            cap_pending    <= shf_read_ready;

            // FIFO data is valid one edge after the pop pulse ends
            if (cap_pending) begin
                hold       <= TxData;
                hold_valid <= 1'b1;
            end else if (sync_end) begin
                hold_valid <= 1'b0;
            end

            if (enter_sync) begin
                SSPCLKOUT <= 1'b1;
                SSPFSSOUT <= 1'b1;
                SSPOE_B   <= 1'b0;
                shift     <= '0;
            end else if (sync_end) begin
                SSPCLKOUT <= 1'b1;
                SSPFSSOUT <= 1'b0;
                shift     <= hold;
                bit_cnt   <= 3'(DATA_W - 1);
            end else if (shift_rise) begin
                if (bit_cnt == 3'd0) begin
                    SSPCLKOUT <= 1'b0;
                    SSPOE_B   <= 1'b1;
                    shift     <= '0;
                end else begin
                    SSPCLKOUT <= 1'b1;
                    shift     <= {shift[DATA_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - 3'd1;
                end
            end else if (div_fall) begin
                SSPCLKOUT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Scoreboard bench for ssp_tx_ctrl: a DIV=1 and a DIV=3 instance fed by FIFO
// models, with monitors decoding the serial lines against queued expectations.
module tb_ssp_tx_ctrl;
    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b0;
    logic [1:0] fifo_empty = 2'b11;
    logic [1:0] rdy, sclk, fss, txd, oe_b, busy;
    logic [7:0] tx_data [2];

    logic [7:0] fifo_q   [2][$];
    logic [7:0] exp_word [2][$];
    int         exp_run  [2][$];
    int         pop_cnt  [2];
    int         last_gap [2];
    int         tests = 0;
    int         fails = 0;

    always #5 PCLK = ~PCLK;

    ssp_tx_ctrl #(.DIV(1)) dut1 (
        .PCLK(PCLK), .CLEAR(CLEAR), .fifo_empty(fifo_empty[0]), .TxData(tx_data[0]),
        .shf_read_ready(rdy[0]), .SSPCLKOUT(sclk[0]), .SSPFSSOUT(fss[0]),
        .SSPTXD(txd[0]), .SSPOE_B(oe_b[0]), .tx_busy(busy[0])
    );

    ssp_tx_ctrl #(.DIV(3)) dut3 (
        .PCLK(PCLK), .CLEAR(CLEAR), .fifo_empty(fifo_empty[1]), .TxData(tx_data[1]),
        .shf_read_ready(rdy[1]), .SSPCLKOUT(sclk[1]), .SSPFSSOUT(fss[1]),
        .SSPTXD(txd[1]), .SSPOE_B(oe_b[1]), .tx_busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int i, input logic [7:0] w);
        fifo_q[i].push_back(w);
        exp_word[i].push_back(w);
    endtask

    // FIFO models: pop on the pulse, present data before the capture edge
    initial begin
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        pop_cnt[0] = 0;
        pop_cnt[1] = 0;
        forever begin
            @(negedge PCLK);
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] === 1'b1) begin
                    if (fifo_q[i].size() == 0) check("pop_from_empty", 1, 0);
                    else tx_data[i] = fifo_q[i].pop_front();
                end
            end
            #2;
            for (int i = 0; i < 2; i++) fifo_empty[i] = (fifo_q[i].size() == 0);
        end
    end

    task automatic mon(input int i, input int div);
        logic       prev_clk = 1'b0, prev_oe = 1'b1, prev_fss = 1'b0, prev_rdy = 1'b0;
        int         run = 0, oe_run = 0, fss_run = 0, dcount = 0, oe_hi = 1;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge PCLK);
            if (CLEAR) begin
                prev_clk = 1'b0; prev_oe = 1'b1; prev_fss = 1'b0; prev_rdy = 1'b0;
                run = 0; oe_run = 0; fss_run = 0; dcount = 0; oe_hi = 1;
                continue;
            end
            if (rdy[i]) begin
                check("pop_single_cycle", prev_rdy, 0);
                if (!prev_rdy) pop_cnt[i]++;
            end
            if (oe_b[i]) begin
                check("idle_lines", {sclk[i], fss[i], txd[i]}, 0);
                if (!prev_oe) begin
                    check("last_half_period", run, div);
                    if (exp_run[i].size() == 0) check("oe_low_unexpected", oe_run, 0);
                    else check("oe_low_len", oe_run, exp_run[i].pop_front());
                end
                oe_hi++;
            end else begin
                if (prev_oe) begin
                    last_gap[i] = oe_hi;
                    oe_hi  = 0;
                    check("frame_start_clk_fss", {sclk[i], fss[i]}, 2'b11);
                    run    = 1;
                    oe_run = 1;
                end else begin
                    oe_run++;
                    if (sclk[i] == prev_clk) run++;
                    else begin
                        check("half_period", run, div);
                        run = 1;
                    end
                    if (sclk[i] && !prev_clk && !fss[i]) begin
                        sh = {sh[6:0], txd[i]};
                        dcount++;
                        if (dcount == 8) begin
                            if (exp_word[i].size() == 0) check("word_unexpected", sh, 9'h100);
                            else check("word", sh, exp_word[i].pop_front());
                        end
                    end
                    if (!sclk[i] && prev_clk && !fss[i] && dcount > 0)
                        check("txd_stable", txd[i], sh[0]);
                end
                if (fss[i]) begin
                    fss_run++;
                    dcount = 0;
                end else if (prev_fss) begin
                    check("fss_len", fss_run, 2 * div);
                    fss_run = 0;
                end
            end
            prev_clk = sclk[i];
            prev_oe  = oe_b[i];
            prev_fss = fss[i];
            prev_rdy = rdy[i];
        end
    endtask

    initial begin
        fork
            mon(0, 1);
            mon(1, 3);
        join_none
    end

    task automatic wait_idle(input int i, input string name);
        int n = 0;
        repeat (4) @(negedge PCLK);
        while ((busy[i] || !fifo_empty[i]) && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        check({name, "_done_in_time"}, (n < 2000), 1);
        repeat (2) @(negedge PCLK);
        check({name, "_busy_low"}, busy[i], 0);
    endtask

    task automatic wait_oe_low(input int i);
        int n = 0;
        while (oe_b[i] !== 1'b0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check("oe_low_seen", (n < 200), 1);
    endtask

    initial begin
        last_gap[0] = 0;
        last_gap[1] = 0;
        #3 CLEAR = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            check("reset_outputs", {rdy[i], sclk[i], fss[i], txd[i], oe_b[i], busy[i]}, 6'b000010);
        repeat (3) @(negedge PCLK);
        #1 CLEAR = 1'b0;

        // single word, DIV=1
        @(negedge PCLK); #1;
        exp_run[0].push_back(18);
        send(0, 8'hA5);
        wait_idle(0, "a5");
        check("a5_pops", pop_cnt[0], 1);

        // two queued words go out back to back
        @(negedge PCLK); #1;
        exp_run[0].push_back(36);
        send(0, 8'h3C);
        send(0, 8'hFF);
        wait_idle(0, "b2b");
        check("b2b_pops", pop_cnt[0], 3);

        // DIV=3 instance
        @(negedge PCLK); #1;
        exp_run[1].push_back(54);
        send(1, 8'h81);
        wait_idle(1, "div3");
        check("div3_pops", pop_cnt[1], 1);

        // reset during bit 3 of 0xF0 (data period covering PCLK 10..11 of the frame)
        @(negedge PCLK); #1;
        send(0, 8'hF0);
        wait_oe_low(0);
        repeat (10) @(negedge PCLK);
        #1;
        check("mid_frame_active", oe_b[0], 0);
        CLEAR = 1'b1;
        #1;
        check("mid_frame_reset", {rdy[0], sclk[0], fss[0], txd[0], oe_b[0], busy[0]}, 6'b000010);
        exp_word[0].delete();
        @(negedge PCLK); #1;
        CLEAR = 1'b0;
        exp_run[0].push_back(18);
        send(0, 8'h55);
        wait_idle(0, "after_reset");
        check("after_reset_pops", pop_cnt[0], 5);

        // late word: FIFO goes non-empty in the last PCLK of the LSB period
        @(negedge PCLK); #1;
        exp_run[0].push_back(18);
        exp_run[0].push_back(18);
        send(0, 8'h12);
        wait_oe_low(0);
        repeat (17) @(negedge PCLK);
        #1;
        send(0, 8'h34);
        wait_idle(0, "late");
        check("late_gap", last_gap[0], 3);
        check("late_pops", pop_cnt[0], 7);

        check("words_left", exp_word[0].size() + exp_word[1].size(), 0);
        check("frames_left", exp_run[0].size() + exp_run[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
